// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into instruction words and
// expands LI into LUI+ADDI. Optional range checking via INST_ENC_RANGE_CHECK_EN.
module inst_encoder #(
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        err,
    output logic        last,
    output logic        dbg_state
);
    // Handshake: a side transfers when its valid and ready are both high in
    // the same cycle; a presented word holds stable until it transfers.

    typedef enum logic {IDLE, LI_ADDI} state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_e      state_q;
    logic        out_valid_q, err_q, last_q;
    logic [31:0] inst_q;
    logic [4:0]  li_rd_q;
    logic [11:0] li_lo_q;

    logic [31:0] word_d;
    logic        err_d, last_d, li2_d;
    logic        fits12, is_shift;
    logic [31:0] li_sum;
    logic        unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign fits12   = (&imm[31:11]) | ~(|imm[31:11]);
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign li_sum   = imm + 32'h0000_0800;

`ifdef INST_ENC_RANGE_CHECK_EN
    logic range_bad;
    always_comb begin
        range_bad = 1'b0;
        case (fmt)
            3'd0, 3'd5: range_bad = !fits12;
            3'd1:       range_bad = is_shift ? (|imm[31:5]) : !fits12;
            3'd2:       range_bad = !fits12;
            3'd3:       range_bad = |imm[11:0];
            3'd4:       range_bad = !((&imm[31:20]) | ~(|imm[31:20])) || imm[0];
            3'd6:       range_bad = !((&imm[31:12]) | ~(|imm[31:12])) || imm[0];
            default:    range_bad = 1'b0;
        endcase
    end
`endif

    always_comb begin
        word_d = '0;
        err_d  = 1'b0;
        last_d = 1'b1;
        li2_d  = 1'b0;
        case (fmt)
            3'd0: word_d = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            3'd1: begin
                if (is_shift)
                    word_d = {1'b0, funct7[5], 5'b0, imm[4:0], rs1, funct3, rd, OP_OPIMM};
                else
                    word_d = {imm[11:0], rs1, funct3, rd, OP_OPIMM};
            end
            3'd2: word_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            3'd3: word_d = {imm[31:12], rd, OP_LUI};
            3'd4: word_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            3'd5: word_d = {imm[11:0], rs1, funct3, rd, OP_JALR};
            3'd6: word_d = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            default: begin
                // LI: a rounded-up LUI compensates for the sign-extended ADDI low part
                if (fits12) begin
                    word_d = {imm[11:0], 5'd0, 3'b000, rd, OP_OPIMM};
                end else begin
                    word_d = {li_sum[31:12], rd, OP_LUI};
                    li2_d  = |imm[11:0];
                    last_d = ~(|imm[11:0]);
                end
            end
        endcase
`ifdef INST_ENC_RANGE_CHECK_EN
        if (range_bad) begin
            word_d = NOP_WORD;
            err_d  = 1'b1;
            last_d = 1'b1;
        end
`endif
    end

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
            li_rd_q     <= '0;
            li_lo_q     <= '0;
        end else if (in_valid && in_ready) begin
            out_valid_q <= 1'b1;
            inst_q      <= word_d;
            err_q       <= err_d;
            last_q      <= last_d;
            li_rd_q     <= rd;
            li_lo_q     <= imm[11:0];
            state_q     <= li2_d ? LI_ADDI : IDLE;
        end else if (state_q == LI_ADDI && out_ready) begin
            inst_q  <= {li_lo_q, li_rd_q, 3'b000, li_rd_q, OP_OPIMM};
            err_q   <= 1'b0;
            last_q  <= 1'b1;
            state_q <= IDLE;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign inst      = inst_q;
    assign err       = err_q;
    assign last      = last_q;
    assign dbg_state = (state_q == LI_ADDI);

endmodule
